// File: rtl/phase_if.sv
// Handshake bundle between the CPU phase sequencer and the datapath/memory side.
// The sequencer uses the slave modport; whoever drives instructions and acks uses master.
interface phase_if #(
   parameter int CNT_W = 32
) ();
   logic             start;
   logic [31:0]      ir;
   logic             mem_ack;
   logic [4:0]       phase;
   logic             mem_req;
   logic             mem_we;
   logic             ir_we;
   logic             pc_inc;
   logic             halted;
   logic             err;
   logic [CNT_W-1:0] retired;

   modport master (
      output start, ir, mem_ack,
      input  phase, mem_req, mem_we, ir_we, pc_inc, halted, err, retired
   );

   modport slave (
      input  start, ir, mem_ack,
      output phase, mem_req, mem_we, ir_we, pc_inc, halted, err, retired
   );
endinterface

// File: rtl/phase_ctrl.sv
// Multi-cycle F/R/X/M/W sequencer: one-hot phase bus, memory handshake with ack
// timeout, HLT stop and retired-instruction counting.
module phase_ctrl #(
   parameter int CNT_W       = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic   clk,
   input  logic   rst,
   phase_if.slave bus
);
   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F    = 3'd1,
      S_R    = 3'd2,
      S_X    = 3'd3,
      S_M    = 3'd4,
      S_W    = 3'd5,
      S_HALT = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [4:0]         phase_q, phase_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic               halted_q, halted_d;
   logic               is_ld_s, is_st_s, is_hlt_s;

   assign is_ld_s  = (bus.ir[31:22] == 10'b1000_1010_01);
   assign is_st_s  = (bus.ir[31:22] == 10'b1000_1000_01);
   assign is_hlt_s = (bus.ir[31:24] == 8'hF4);

   // Next-state, wait counter, sticky error and retire count.
   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      err_d     = err_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_F;
            else           state_d = S_IDLE;
         end
         S_F, S_M: begin
            // An ack on the timeout cycle still wins over the error halt.
            if (bus.mem_ack) begin
               state_d = (state_q == S_F) ? S_R : S_W;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               wait_d  = wait_q + WAIT_W'(1);
            end
         end
         S_R: begin
            if (is_hlt_s) state_d = S_HALT;
            else          state_d = S_X;
         end
         S_X: begin
            if (is_ld_s || is_st_s) state_d = S_M;
            else                    state_d = S_W;
         end
         S_W: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_F;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs, registered alongside the state they decode.
   always_comb begin
      case (state_d)
         S_F:     phase_d = 5'b00001;
         S_R:     phase_d = 5'b00010;
         S_X:     phase_d = 5'b00100;
         S_M:     phase_d = 5'b01000;
         S_W:     phase_d = 5'b10000;
         default: phase_d = 5'b00000;
      endcase
      mem_req_d = (state_d == S_F) || (state_d == S_M);
      mem_we_d  = (state_d == S_M) && is_st_s;
      halted_d  = (state_d == S_HALT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         err_q     <= 1'b0;
         retired_q <= '0;
         phase_q   <= 5'b00000;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         err_q     <= err_d;
         retired_q <= retired_d;
         phase_q   <= phase_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         halted_q  <= halted_d;
      end
   end

   assign bus.phase   = phase_q;
   assign bus.mem_req = mem_req_q;
   assign bus.mem_we  = mem_we_q;
   assign bus.halted  = halted_q;
   assign bus.err     = err_q;
   assign bus.retired = retired_q;
   assign bus.ir_we   = (state_q == S_F) && bus.mem_ack;
   assign bus.pc_inc  = (state_q == S_F) && bus.mem_ack;
endmodule
